md_unit: RTL and testbench

//  Multiply/divide unit in the E stage; the responder to the decoder's MDUOp/start interface.

---
 rtl/md_unit.sv | 166 ++++++++++++++++
 tb/tb_md_unit.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/md_unit.sv
// md_unit: E-stage multiply/divide unit. Multi-cycle ops are computed at
// launch into a holding register and committed to HI/LO after a fixed
// latency. mthi/mtlo write immediately; mfhi/mflo are combinational reads.
module md_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [3:0]  MDUOp,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO,
    output logic [31:0] MDU_out,
    output logic        dbg_state_o
);

    localparam logic [3:0] OP_MULT  = 4'b0001;
    localparam logic [3:0] OP_MULTU = 4'b0010;
    localparam logic [3:0] OP_DIV   = 4'b0011;
    localparam logic [3:0] OP_DIVU  = 4'b0100;
    localparam logic [3:0] OP_MFHI  = 4'b0101;
    localparam logic [3:0] OP_MFLO  = 4'b0110;
    localparam logic [3:0] OP_MTHI  = 4'b0111;
    localparam logic [3:0] OP_MTLO  = 4'b1000;
    localparam logic [3:0] OP_MADD  = 4'b1001;
    localparam logic [3:0] OP_MSUB  = 4'b1010;

    localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES);
    localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   tmp_hi_q, tmp_hi_d, tmp_lo_q, tmp_lo_d;

    logic          is_mc, is_div;
    logic [63:0]   hilo, a_sx, b_sx, prod_s, prod_u;
    logic [31:0]   q_s, r_s, res_hi, res_lo;

    assign is_div = (MDUOp == OP_DIV) || (MDUOp == OP_DIVU);
    assign is_mc  = (MDUOp == OP_MULT) || (MDUOp == OP_MULTU) || is_div ||
                    (MDUOp == OP_MADD) || (MDUOp == OP_MSUB);

    assign hilo   = {hi_q, lo_q};
    assign a_sx   = {{32{A[31]}}, A};
    assign b_sx   = {{32{B[31]}}, B};
    // Low 64 bits of the sign-extended product equal the signed 32x32 product.
    assign prod_s = a_sx * b_sx;
    assign prod_u = {32'b0, A} * {32'b0, B};
    assign q_s    = $signed(A) / $signed(B);
    assign r_s    = $signed(A) % $signed(B);

    // Result of the op being launched; divide by zero reproduces current HI/LO
    // so the commit at completion leaves them unchanged.
    always_comb begin
        res_hi = hi_q;
        res_lo = lo_q;
        unique case (MDUOp)
            OP_MULT:  {res_hi, res_lo} = prod_s;
            OP_MULTU: {res_hi, res_lo} = prod_u;
            OP_MADD:  {res_hi, res_lo} = hilo + prod_s;
            OP_MSUB:  {res_hi, res_lo} = hilo - prod_s;
            OP_DIV: begin
                if (B == 32'h0) begin
                    res_hi = hi_q;
                    res_lo = lo_q;
                end else if (A == 32'h8000_0000 && B == 32'hFFFF_FFFF) begin
                    res_hi = 32'h0;
                    res_lo = 32'h8000_0000;
                end else begin
                    res_hi = r_s;
                    res_lo = q_s;
                end
            end
            OP_DIVU: begin
                if (B != 32'h0) begin
                    res_hi = A % B;
                    res_lo = A / B;
                end
            end
            default: ;
        endcase
    end

    // Next-state logic: launch, countdown/commit, and direct HI/LO moves.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        tmp_hi_d = tmp_hi_q;
        tmp_lo_d = tmp_lo_q;
        unique case (state_q)
            IDLE: begin
                if (start && is_mc) begin
                    tmp_hi_d = res_hi;
                    tmp_lo_d = res_lo;
                    cnt_d    = is_div ? DIV_LOAD : MULT_LOAD;
                    busy_d   = 1'b1;
                    state_d  = BUSY;
                end else if (MDUOp == OP_MTHI) begin
                    hi_d = A;
                end else if (MDUOp == OP_MTLO) begin
                    lo_d = A;
                end
            end
            BUSY: begin
                if (cnt_q == CNT_ONE) begin
                    hi_d    = tmp_hi_q;
                    lo_d    = tmp_lo_q;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset discards any in-flight result.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            hi_q     <= 32'h0;
            lo_q     <= 32'h0;
            tmp_hi_q <= 32'h0;
            tmp_lo_q <= 32'h0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            tmp_hi_q <= tmp_hi_d;
            tmp_lo_q <= tmp_lo_d;
        end
    end

    // Combinational mfhi/mflo read port.
    always_comb begin
        MDU_out = 32'h0;
        if (MDUOp == OP_MFHI)      MDU_out = hi_q;
        else if (MDUOp == OP_MFLO) MDU_out = lo_q;
    end

    assign busy        = busy_q;
    assign HI          = hi_q;
    assign LO          = lo_q;
    assign dbg_state_o = (state_q == BUSY);

endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed tests for md_unit. Each launch pushes the expected
// {HI,LO} and busy length; a monitor pops and compares on every busy fall.
module tb_md_unit;

    logic        clk;
    logic        reset;
    logic        start;
    logic [3:0]  MDUOp;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] MDU_out;
    logic        dbg_state;

    int errors = 0;
    int checks = 0;

    logic [63:0] exp_q[$];
    int          exp_len_q[$];

    md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .MDUOp       (MDUOp),
        .A           (A),
        .B           (B),
        .busy        (busy),
        .HI          (HI),
        .LO          (LO),
        .MDU_out     (MDU_out),
        .dbg_state_o (dbg_state)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: a busy falling edge marks a completion.
    initial begin
        logic        busy_prev;
        int          busy_cnt;
        logic [63:0] e;
        int          l;
        busy_prev = 1'b0;
        busy_cnt  = 0;
        forever begin
            @(negedge clk);
            if (busy === 1'b1) busy_cnt++;
            if (busy_prev && busy === 1'b0) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_completion: got HI=0x%0h LO=0x%0h expected no completion", HI, LO);
                end else begin
                    e = exp_q.pop_front();
                    l = exp_len_q.pop_front();
                    check("sb_hilo", {HI, LO}, e);
                    check("sb_busy_len", 64'(busy_cnt), 64'(l));
                end
                busy_cnt = 0;
            end
            busy_prev = busy;
        end
    end

    // Drivers: all called just after a rising edge.
    task automatic launch(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int len);
        exp_q.push_back(exp);
        exp_len_q.push_back(len);
        start = 1'b1; MDUOp = op; A = a; B = b;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'b0000; A = 32'h0; B = 32'h0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) begin
            checks++;
            errors++;
            $display("FAIL wait_idle: busy still 1 after %0d cycles expected 0", n);
        end
        @(negedge clk); #1;
        @(posedge clk); #1;
    endtask

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [63:0] exp, input int len);
        launch(op, a, b, exp, len);
        check("busy_after_launch", {63'b0, busy}, 64'd1);
        wait_idle();
    endtask

    task automatic move(input logic [3:0] op, input logic [31:0] a);
        MDUOp = op; A = a;
        @(posedge clk); #1;
        MDUOp = 4'b0000; A = 32'h0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; MDUOp = 4'b0000; A = 32'h0; B = 32'h0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_hilo", {HI, LO}, 64'd0);

        // 1: signed mult
        run_op(4'b0001, 32'hFFFF_FFFE, 32'h3, 64'hFFFF_FFFF_FFFF_FFFA, 5);
        // 2: multu, madd, msub chain
        run_op(4'b0010, 32'hFFFF_FFFF, 32'h2, 64'h0000_0001_FFFF_FFFE, 5);
        run_op(4'b1001, 32'h1, 32'h1, 64'h0000_0001_FFFF_FFFF, 5);
        run_op(4'b1010, 32'h2, 32'h1, 64'h0000_0001_FFFF_FFFD, 5);
        // 3: div/divu of -7 by 2, then signed overflow case
        run_op(4'b0011, 32'hFFFF_FFF9, 32'h2, 64'hFFFF_FFFF_FFFF_FFFD, 10);
        run_op(4'b0100, 32'hFFFF_FFF9, 32'h2, 64'h0000_0001_7FFF_FFFC, 10);
        run_op(4'b0011, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, 10);

        // 4: mthi/mtlo, divide by zero, mfhi/mflo
        move(4'b0111, 32'h11);
        check("mthi", {32'h0, HI}, 64'h11);
        move(4'b1000, 32'h22);
        check("mtlo", {32'h0, LO}, 64'h22);
        run_op(4'b0011, 32'h1234, 32'h0, 64'h0000_0011_0000_0022, 10);
        MDUOp = 4'b0101; #1;
        check("mfhi", {32'h0, MDU_out}, 64'h11);
        MDUOp = 4'b0110; #1;
        check("mflo", {32'h0, MDU_out}, 64'h22);
        MDUOp = 4'b1111; #1;
        check("noop_out", {32'h0, MDU_out}, 64'h0);
        MDUOp = 4'b0000;

        // start with a non-multi-cycle op must not raise busy
        start = 1'b1; MDUOp = 4'b0101;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'b0000;
        check("start_mfhi_no_busy", {63'b0, busy}, 64'd0);

        // 5: second start during busy cycle 3 of a div is ignored
        launch(4'b0011, 32'd100, 32'd7, 64'h0000_0002_0000_000E, 10);
        repeat (2) begin @(posedge clk); #1; end
        start = 1'b1; MDUOp = 4'b0001; A = 32'h5; B = 32'h5;
        @(posedge clk); #1;
        start = 1'b0; MDUOp = 4'b0000; A = 32'h0; B = 32'h0;
        wait_idle();
        repeat (8) begin @(posedge clk); #1; end
        check("busy_stays_low", {63'b0, busy}, 64'd0);
        check("hilo_after_ignored", {HI, LO}, 64'h0000_0002_0000_000E);

        // 6: reset during busy cycle 2 aborts the mult
        launch(4'b0001, 32'h3, 32'h4, 64'h0, 2);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'h0);
        repeat (10) begin @(posedge clk); #1; end
        check("abort_no_late_write", {HI, LO}, 64'h0);

        // reset and start together: reset wins
        reset = 1'b1; start = 1'b1; MDUOp = 4'b0001; A = 32'h7; B = 32'h7;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0; MDUOp = 4'b0000; A = 32'h0; B = 32'h0;
        check("reset_beats_start", {63'b0, busy}, 64'd0);
        repeat (8) begin @(posedge clk); #1; end
        check("reset_beats_start_hilo", {HI, LO}, 64'h0);

        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
